vram_arbiter: RTL and testbench

Arbitrates and sequences all accesses to the asynchronous VRAM macro (`ram_m`: address, bidirectional data, active-high we/oe/cs). It has two requesters:

- **GPU pixel-fetch read port**: real-time, and it has priority.
- **CPU write port**: buffered in a small write FIFO.

The arbiter generates glitch-free strobe sequences so that oe and we are never active together and data is never driven while oe is high. It sits between the bus-interface/pixel pipeline and the VRAM instance in the GPU top.

---
 rtl/vram_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Sequences GPU reads and buffered CPU writes onto an asynchronous VRAM macro.
// All strobes are registered so oe/we never overlap and data is never driven under oe.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 16
`endif

module vram_arbiter #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned ADDR_WIDTH   = `VRAM_ADDR_WIDTH,
   parameter int unsigned RD_CYCLES    = 2,
   parameter int unsigned WR_CYCLES    = 1,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               gpu_rd_valid,
   input  logic [ADDR_WIDTH-1:0]              gpu_rd_addr,
   output logic                               gpu_rd_ready,
   output logic [DATA_WIDTH-1:0]              gpu_rd_data,
   output logic                               gpu_rd_data_valid,
   input  logic                               cpu_wr_valid,
   input  logic [ADDR_WIDTH-1:0]              cpu_wr_addr,
   input  logic [DATA_WIDTH-1:0]              cpu_wr_data,
   output logic                               cpu_wr_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    wr_level,
   output logic [ADDR_WIDTH-1:0]              ram_address,
   inout  logic [DATA_WIDTH-1:0]              ram_data,
   output logic                               ram_we,
   output logic                               ram_oe,
   output logic                               ram_cs
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned MaxCyc = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
   localparam int unsigned TimW = $clog2(MaxCyc + 1);

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StWrSetup,
      StWrPulse,
      StWrHold
   } state_e;

   state_e                  state_q;
   logic [TimW-1:0]         timer_q;
   logic [CntW-1:0]         starve_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    ram_drive_q;

   logic [ADDR_WIDTH-1:0]   fifo_addr_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
   logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [LvlW-1:0]         level_q, level_d;

   logic fifo_nonempty;
   logic force_wr;
   logic in_idle;
   logic push;
   logic rd_grant;
   logic wr_grant;

   assign fifo_nonempty = (level_q != '0);
   assign force_wr      = fifo_nonempty && (starve_q == CntW'(STARVE_LIMIT));
   assign in_idle       = (state_q == StIdle);
   assign gpu_rd_ready  = rst_n && in_idle && !force_wr;
   assign cpu_wr_ready  = rst_n && (level_q < LvlW'(FIFO_DEPTH));
   assign push          = cpu_wr_valid && cpu_wr_ready;
   assign rd_grant      = in_idle && gpu_rd_valid && !force_wr;
   assign wr_grant      = in_idle && !rd_grant && fifo_nonempty;
   assign wr_level      = level_q;

   assign ram_data = ram_drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

   // Write buffer: storage carries no reset, emptiness lives in the pointers and level.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= cpu_wr_addr;
         fifo_data_q[wr_ptr_q] <= cpu_wr_data;
      end
   end

   always_comb begin
      level_d = level_q;
      if (push && !wr_grant) begin
         level_d = level_q + 1'b1;
      end else if (wr_grant && !push) begin
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         level_q <= level_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (wr_grant) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= StIdle;
         timer_q           <= '0;
         starve_q          <= '0;
         wdata_q           <= '0;
         ram_drive_q       <= 1'b0;
         ram_address       <= '0;
         ram_cs            <= 1'b0;
         ram_oe            <= 1'b0;
         ram_we            <= 1'b0;
         gpu_rd_data       <= '0;
         gpu_rd_data_valid <= 1'b0;
      end else begin
         gpu_rd_data_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (rd_grant) begin
                  state_q     <= StRd;
                  timer_q     <= TimW'(RD_CYCLES - 1);
                  ram_address <= gpu_rd_addr;
                  ram_cs      <= 1'b1;
                  ram_oe      <= 1'b1;
                  // A granted read never sees starve_q at the limit, so no overflow here.
                  starve_q    <= fifo_nonempty ? starve_q + 1'b1 : '0;
               end else if (wr_grant) begin
                  state_q     <= StWrSetup;
                  ram_address <= fifo_addr_q[rd_ptr_q];
                  wdata_q     <= fifo_data_q[rd_ptr_q];
                  ram_cs      <= 1'b1;
                  ram_drive_q <= 1'b1;
                  starve_q    <= '0;
               end else begin
                  starve_q    <= '0;
               end
            end
            StRd: begin
               if (timer_q == '0) begin
                  state_q           <= StIdle;
                  ram_cs            <= 1'b0;
                  ram_oe            <= 1'b0;
                  gpu_rd_data       <= ram_data;
                  gpu_rd_data_valid <= 1'b1;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            StWrSetup: begin
               state_q <= StWrPulse;
               ram_we  <= 1'b1;
               timer_q <= TimW'(WR_CYCLES - 1);
            end
            StWrPulse: begin
               if (timer_q == '0) begin
                  state_q <= StWrHold;
                  ram_we  <= 1'b0;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            StWrHold: begin
               state_q     <= StIdle;
               ram_cs      <= 1'b0;
               ram_drive_q <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with an async SRAM model, read/write scoreboards
// and a per-cycle strobe protocol monitor.
module tb_vram_arbiter;

   localparam int RD_CYCLES = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        gpu_rd_valid;
   logic [15:0] gpu_rd_addr;
   logic        gpu_rd_ready;
   logic [7:0]  gpu_rd_data;
   logic        gpu_rd_data_valid;
   logic        cpu_wr_valid;
   logic [15:0] cpu_wr_addr;
   logic [7:0]  cpu_wr_data;
   logic        cpu_wr_ready;
   logic [2:0]  wr_level;
   logic [15:0] ram_address;
   wire  [7:0]  ram_data;
   logic        ram_we, ram_oe, ram_cs;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [7:0] mem     [0:65535];
   logic [7:0] ref_mem [0:65535];

   logic [7:0]  exp_rd_data[$];
   int          exp_rd_cyc[$];
   logic [15:0] exp_wr_addr[$];
   logic [7:0]  exp_wr_data[$];
   logic        we_prev = 1'b0;

   vram_arbiter #(
      .DATA_WIDTH  (8),
      .ADDR_WIDTH  (16),
      .RD_CYCLES   (RD_CYCLES),
      .WR_CYCLES   (1),
      .FIFO_DEPTH  (4),
      .STARVE_LIMIT(8)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .gpu_rd_valid     (gpu_rd_valid),
      .gpu_rd_addr      (gpu_rd_addr),
      .gpu_rd_ready     (gpu_rd_ready),
      .gpu_rd_data      (gpu_rd_data),
      .gpu_rd_data_valid(gpu_rd_data_valid),
      .cpu_wr_valid     (cpu_wr_valid),
      .cpu_wr_addr      (cpu_wr_addr),
      .cpu_wr_data      (cpu_wr_data),
      .cpu_wr_ready     (cpu_wr_ready),
      .wr_level         (wr_level),
      .ram_address      (ram_address),
      .ram_data         (ram_data),
      .ram_we           (ram_we),
      .ram_oe           (ram_oe),
      .ram_cs           (ram_cs)
   );

   always #5 clk = ~clk;

   // SRAM model: drives data under cs&oe, captures data while we is high.
   assign ram_data = (ram_cs && ram_oe) ? mem[ram_address] : 8'hzz;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_cs && ram_we) mem[ram_address] = ram_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboards and protocol checks, all sampled on the falling edge.
   always @(negedge clk) begin
      if (gpu_rd_data_valid) begin
         if (exp_rd_data.size() == 0) begin
            chk("rd_unexpected", 1, 0);
         end else begin
            chk("rd_data", gpu_rd_data, exp_rd_data.pop_front());
            chk("rd_latency", cyc, exp_rd_cyc.pop_front());
         end
      end
      if (rst_n && gpu_rd_valid && gpu_rd_ready) begin
         exp_rd_data.push_back(ref_mem[gpu_rd_addr]);
         exp_rd_cyc.push_back(cyc + 1 + RD_CYCLES);
      end
      if (ram_we && !we_prev) begin
         if (exp_wr_addr.size() == 0) begin
            chk("wr_unexpected", 1, 0);
         end else begin
            chk("wr_addr", ram_address, exp_wr_addr.pop_front());
            chk("wr_data", ram_data, exp_wr_data.pop_front());
         end
      end
      if (rst_n && cpu_wr_valid && cpu_wr_ready) begin
         exp_wr_addr.push_back(cpu_wr_addr);
         exp_wr_data.push_back(cpu_wr_data);
         ref_mem[cpu_wr_addr] = cpu_wr_data;
      end
      we_prev <= ram_we;
      chk("proto_oe_we", ram_oe && ram_we, 0);
      chk("proto_oe_drive", ram_oe && dut.ram_drive_q, 0);
   end

   task automatic gpu_read(input logic [15:0] a);
      logic ok = 1'b0;
      @(posedge clk); #1;
      gpu_rd_valid = 1'b1;
      gpu_rd_addr  = a;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (gpu_rd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("rd_accept_timeout", ok, 1);
      @(posedge clk); #1;
      gpu_rd_valid = 1'b0;
   endtask

   task automatic expect_rd_data(input string tag, input logic [7:0] exp);
      logic ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (gpu_rd_data_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk({tag, "_valid_timeout"}, ok, 1);
      chk(tag, gpu_rd_data, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      int   cnt;
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = i[7:0] ^ 8'h5A;
         ref_mem[i] = i[7:0] ^ 8'h5A;
      end
      mem[16'h0123]     = 8'hA5;
      ref_mem[16'h0123] = 8'hA5;
      rst_n = 1'b0;
      gpu_rd_valid = 1'b0;
      gpu_rd_addr  = '0;
      cpu_wr_valid = 1'b0;
      cpu_wr_addr  = '0;
      cpu_wr_data  = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_strobes", {ram_cs, ram_oe, ram_we}, 3'b000);
      chk("rst_addr", ram_address, 16'h0000);
      chk("rst_rd_data", gpu_rd_data, 8'h00);
      chk("rst_rd_valid", gpu_rd_data_valid, 0);
      chk("rst_rd_ready", gpu_rd_ready, 0);
      chk("rst_wr_ready", cpu_wr_ready, 0);
      chk("rst_level", wr_level, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_rd_ready", gpu_rd_ready, 1);
      chk("post_rst_wr_ready", cpu_wr_ready, 1);

      // Single read
      @(posedge clk); #1;
      gpu_rd_valid = 1'b1;
      gpu_rd_addr  = 16'h0123;
      @(negedge clk);
      chk("rd1_ready", gpu_rd_ready, 1);
      @(posedge clk); #1;
      gpu_rd_valid = 1'b0;
      @(negedge clk);
      chk("rd1_cyc1", {ram_cs, ram_oe, ram_we}, 3'b110);
      chk("rd1_addr", ram_address, 16'h0123);
      @(negedge clk);
      chk("rd1_cyc2", {ram_cs, ram_oe, ram_we, gpu_rd_data_valid}, 4'b1100);
      @(negedge clk);
      chk("rd1_done", {ram_cs, ram_oe, ram_we, gpu_rd_data_valid}, 4'b0001);
      chk("rd1_data", gpu_rd_data, 8'hA5);
      @(negedge clk);
      chk("rd1_pulse", gpu_rd_data_valid, 0);

      // Single write then read-back
      @(posedge clk); #1;
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = 16'h0456;
      cpu_wr_data  = 8'h3C;
      @(negedge clk);
      chk("wr1_ready", cpu_wr_ready, 1);
      @(posedge clk); #1;
      cpu_wr_valid = 1'b0;
      @(negedge clk);
      chk("wr1_level1", wr_level, 1);
      chk("wr1_idle", ram_cs, 0);
      @(negedge clk);
      chk("wr1_setup", {ram_cs, ram_oe, ram_we}, 3'b100);
      chk("wr1_popped", wr_level, 0);
      @(negedge clk);
      chk("wr1_pulse", {ram_cs, ram_oe, ram_we}, 3'b101);
      chk("wr1_bus", {ram_address, ram_data}, {16'h0456, 8'h3C});
      @(negedge clk);
      chk("wr1_hold", {ram_cs, ram_oe, ram_we}, 3'b100);
      @(negedge clk);
      chk("wr1_end", {ram_cs, ram_oe, ram_we}, 3'b000);
      gpu_read(16'h0456);
      expect_rd_data("wr1_readback", 8'h3C);

      // FIFO full while reads hold the bus
      @(posedge clk); #1;
      gpu_rd_valid = 1'b1;
      gpu_rd_addr  = 16'h0123;
      for (int i = 0; i < 5; i++) begin
         cpu_wr_valid = 1'b1;
         cpu_wr_addr  = 16'h0300 + 16'(i);
         cpu_wr_data  = 8'hC0 + 8'(i);
         @(negedge clk);
         chk("full_ready", cpu_wr_ready, (i < 4) ? 1 : 0);
         if (i < 4) begin
            @(posedge clk); #1;
         end
      end
      chk("full_level", wr_level, 4);
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (cpu_wr_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("full_fifth_timeout", ok, 1);
      @(posedge clk); #1;
      cpu_wr_valid = 1'b0;
      gpu_rd_valid = 1'b0;
      ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (wr_level == 0 && !ram_cs) begin
            ok = 1'b1;
            break;
         end
      end
      chk("full_drain_timeout", ok, 1);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("full_mem", mem[16'h0300 + 16'(i)], 8'hC0 + 8'(i));
      end

      // Starvation bound
      @(posedge clk); #1;
      gpu_rd_valid = 1'b1;
      gpu_rd_addr  = 16'h0123;
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (gpu_rd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("st_first_timeout", ok, 1);
      @(posedge clk); #1;
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = 16'h0200;
      cpu_wr_data  = 8'h5E;
      @(negedge clk);
      chk("st_push_ready", cpu_wr_ready, 1);
      @(posedge clk); #1;
      cpu_wr_valid = 1'b0;
      cnt = 0;
      ok  = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (gpu_rd_ready) begin
            cnt++;
         end else if (!ram_cs) begin
            ok = 1'b1;
            break;
         end
      end
      chk("st_force_timeout", ok, 1);
      chk("st_read_count", cnt, 8);
      @(negedge clk);
      chk("st_wr_setup", {ram_cs, ram_oe, ram_we}, 3'b100);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (gpu_rd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("st_resume_timeout", ok, 1);
      chk("st_level_after", wr_level, 0);
      @(posedge clk); #1;
      gpu_rd_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("st_mem", mem[16'h0200], 8'h5E);

      // Reset in the middle of a write pulse
      @(posedge clk); #1;
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = 16'h0500;
      cpu_wr_data  = 8'h77;
      @(negedge clk);
      @(posedge clk); #1;
      cpu_wr_addr  = 16'h0501;
      cpu_wr_data  = 8'h78;
      @(negedge clk);
      @(posedge clk); #1;
      cpu_wr_valid = 1'b0;
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (ram_we) begin
            ok = 1'b1;
            break;
         end
      end
      chk("mid_we_timeout", ok, 1);
      #1;
      rst_n = 1'b0;
      exp_wr_addr.delete();
      exp_wr_data.delete();
      exp_rd_data.delete();
      exp_rd_cyc.delete();
      #1;
      chk("mid_strobes", {ram_cs, ram_oe, ram_we}, 3'b000);
      chk("mid_drive", dut.ram_drive_q, 0);
      chk("mid_level", wr_level, 0);
      chk("mid_rd_ready", gpu_rd_ready, 0);
      chk("mid_wr_ready", cpu_wr_ready, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_post_level", wr_level, 0);
      chk("mid_post_idle", {ram_cs, gpu_rd_ready}, 2'b01);
      gpu_read(16'h0123);
      expect_rd_data("mid_post_read", 8'hA5);

      repeat (5) @(negedge clk);
      chk("rd_queue_empty", exp_rd_data.size(), 0);
      chk("wr_queue_empty", exp_wr_addr.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
